// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: FSM states, pc_src codes,
// trap causes and the RV32I base opcodes, plus an opcode classifier.
package multicycle_sequencer_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd7;

    localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SRC_IMM   = 2'd1;
    localparam logic [1:0] PC_SRC_ALU   = 2'd2;

    localparam logic [1:0] CAUSE_NONE        = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL_OP  = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL_BR  = 2'd2;
    localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'd3;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_ILLEGAL
    } op_class_e;

    function automatic op_class_e classify_opcode(input logic [6:0] op);
        case (op)
            OP_R:      return CLS_R;
            OP_I:      return CLS_I;
            OP_LOAD:   return CLS_LOAD;
            OP_STORE:  return CLS_STORE;
            OP_BRANCH: return CLS_BRANCH;
            OP_JAL:    return CLS_JAL;
            OP_JALR:   return CLS_JALR;
            OP_LUI:    return CLS_LUI;
            OP_AUIPC:  return CLS_AUIPC;
            default:   return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Counts consecutive stalled memory cycles and flags a timeout once the count
// has reached the limit while the port is still not ready.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

    logic [7:0] wait_count;

    assign timeout = active && !mem_ready && (wait_count == LIMIT);

    // Leaving the waiting state always coincides with ready or timeout, so clearing here also covers state changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_count <= 8'd0;
        end else if (active && !mem_ready && !timeout) begin
            wait_count <= wait_count + 8'd1;
        end else begin
            wait_count <= 8'd0;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Control FSM for the multi-cycle RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives the datapath strobes, traps on illegal encodings or memory timeout.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_addr_sel,
    output logic             reg_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [1:0] cause_d;
    logic       retire;
    logic       waiting;
    logic       timeout;
    op_class_e  op_class;

    assign state    = state_q;
    assign op_class = classify_opcode(opcode);
    assign waiting  = (state_q == ST_FETCH) || (state_q == ST_MEM);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (waiting),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_comb begin
        state_d      = state_q;
        cause_d      = CAUSE_NONE;
        retire       = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr_sel = 1'b0;
        reg_write    = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_PLUS4;

        case (state_q)
            ST_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_MEM_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (op_class == CLS_ILLEGAL) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL_OP;
                end else if (op_class == CLS_BRANCH &&
                             (func3 == 3'b010 || func3 == 3'b011)) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL_BR;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_class == CLS_BRANCH) begin
                    pc_write = 1'b1;
                    pc_src   = br_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                end else if (op_class == CLS_LOAD || op_class == CLS_STORE) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                mem_addr_sel = 1'b1;
                mem_write    = (op_class == CLS_STORE);
                mem_read     = (op_class != CLS_STORE);
                if (mem_ready) begin
                    if (op_class == CLS_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_MEM_TIMEOUT;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_d   = ST_FETCH;
                if (op_class == CLS_JAL) begin
                    pc_src = PC_SRC_IMM;
                end else if (op_class == CLS_JALR) begin
                    pc_src = PC_SRC_ALU;
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Strobes are masked during reset so an abandoned access never writes anything.
        if (!rst_n) begin
            ir_write     = 1'b0;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            mem_addr_sel = 1'b0;
            reg_write    = 1'b0;
            pc_write     = 1'b0;
            pc_src       = PC_SRC_PLUS4;
            retire       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
            instret    <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == ST_TRAP && state_q != ST_TRAP) begin
                trap       <= 1'b1;
                trap_cause <= cause_d;
            end
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Control FSM for the multi-cycle RV32I core: one shared instruction/data memory port, one ALU.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and issues the datapath enables.
- Handles the memory ready handshake and a bounded wait timeout.
- Keeps a retired-instruction counter. The existing combinational decoder still supplies ALUctl, ALUSrc and branch-type signals; this block owns timing only.

Parameters:
- CNT_W, 32, width of instret counter (wraps modulo 2^CNT_W)
- MEM_TIMEOUT, 15, max consecutive cycles waiting for mem_ready before bus-error trap (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low; the only reset in the block
- opcode  in  7  instruction opcode from IR (valid from DECODE on)
- func3  in  3  instruction func3 from IR
- br_taken  in  1  branch condition result from ALU/comparator, valid in EXEC
- mem_ready  in  1  memory port completes the current access this cycle
- state  out  3  current FSM state (encoding in define.v)
- ir_write  out  1  load IR from memory read data
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- reg_write  out  1  register file write enable
- pc_write  out  1  update PC
- pc_src  out  2  0 = PC+4, 1 = PC+imm (branch/jal), 2 = ALU result with bit0 cleared (jalr)
- trap  out  1  sticky: core halted
- trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = illegal branch func3, 3 = memory timeout
- instret  out  CNT_W  instructions retired

Behaviour:
- Registered: state, wait counter, trap, trap_cause, instret. All strobes are combinational from state plus opcode/func3/br_taken/mem_ready.
- Reset (rst_n low at a clk edge): state = FETCH, trap = 0, trap_cause = 0, instret = 0, wait counter = 0. All strobes are 0 while rst_n is low. Reset mid-instruction or mid-access abandons it; no PC or register write occurs.
- FETCH:
  - mem_read = 1, mem_addr_sel = 0.
  - On mem_ready: ir_write = 1, next state DECODE.
- DECODE:
  - 1 cycle, no strobes.
  - Legal opcodes: R, I, load, store, B, jal, jalr, lui, auipc.
  - Any other opcode goes to TRAP with cause 1.
  - B with func3 = 010 or 011 goes to TRAP with cause 2.
  - Otherwise next state EXEC.
- EXEC:
  - B: pc_write = 1, pc_src = 1 if br_taken else 0. Retire, go to FETCH.
  - load/store: go to MEM.
  - All others: go to WB.
- MEM:
  - mem_addr_sel = 1; mem_read = load, mem_write = store.
  - Held until mem_ready.
  - On mem_ready, store: pc_write = 1, pc_src = 0, retire, go to FETCH.
  - On mem_ready, load: go to WB.
- WB:
  - reg_write = 1, pc_write = 1.
  - pc_src = 1 for jal, 2 for jalr, 0 otherwise.
  - Retire, go to FETCH.
- TRAP: terminal, all strobes 0. Only reset exits.
- Exactly one pc_write per retired instruction, always in the retiring cycle. Retire means instret += 1 on that edge.
- Timeout:
  - The wait counter increments each FETCH/MEM cycle with mem_ready = 0 and clears on mem_ready or state change.
  - When it reaches MEM_TIMEOUT with mem_ready still 0, the next state is TRAP with cause 3.
  - mem_ready in the same cycle as the limit wins: the access completes.
- A store never asserts reg_write. A trap never retires or writes the PC.
- Zero-wait latency: branch 3 cycles, R/I/U/jal/jalr/store 4, load 5. Each memory wait cycle adds 1.
- instret wraps from all-ones to 0 with no flag.

Decomposition:
- State encodings (FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7), pc_src codes and trap cause codes go in define.v, next to the existing opcode macros. The bench uses the same file.
- One natural sub-module: mem_wait_timer (counter plus compare, outputs timeout).

Test Plan:
- add (opcode 0110011), mem_ready always 1 -> states 0,1,2,4,0; reg_write and pc_write with pc_src = 0 only in the WB cycle; instret = 1 after 4 cycles.
- lw with mem_ready low for 3 MEM cycles -> mem_read and mem_addr_sel = 1 held 4 cycles; WB follows; total 8 cycles; one reg_write.
- beq with br_taken = 1, then bne with br_taken = 0 -> EXEC pc_src = 1 then 0, both 3 cycles; reg_write never asserted; instret += 2.
- jalr -> WB cycle has reg_write = 1, pc_write = 1, pc_src = 2.
- opcode 0000000 -> TRAP after DECODE, trap_cause = 1, strobes 0 for 20 cycles; rst_n low one edge -> FETCH, trap = 0, instret = 0.
- FETCH with mem_ready held 0 and MEM_TIMEOUT = 15 -> TRAP with cause 3 on the 16th edge. Repeat with mem_ready = 1 on the limit cycle -> DECODE, no trap.
